// File: rtl/prog_freq_divider_pkg.sv
// rtl/prog_freq_divider_pkg.sv - mode encodings shared by the function-generator blocks
package prog_freq_divider_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

endpackage

// File: rtl/div_shadow_regs.sv
// rtl/div_shadow_regs.sv - shadow settings, load validation, ack/err and pending flag
module div_shadow_regs
    import prog_freq_divider_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [1:0]       mode_in,
    input  logic             div_load,
    input  logic             apply,
    output logic [WIDTH-1:0] sh_div,
    output logic [WIDTH-1:0] sh_duty,
    output mode_t            sh_mode,
    output logic             div_ack,
    output logic             div_err,
    output logic             pending
);

    logic load_ok;

    assign load_ok = div_load && (div_in != '0) && (mode_in != 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_div  <= WIDTH'(DEFAULT_DIV);
            sh_duty <= WIDTH'(DEFAULT_DIV / 2);
            sh_mode <= MODE_TOGGLE;
            div_ack <= 1'b0;
            div_err <= 1'b0;
            pending <= 1'b0;
        end else begin
            div_ack <= load_ok;
            div_err <= div_load && !load_ok;
            // A new request outranks a coincident apply: the active side has
            // already taken the old shadow values, the new ones wait a period.
            if (load_ok) begin
                sh_div  <= div_in;
                sh_duty <= duty_in;
                sh_mode <= mode_t'(mode_in);
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prog_freq_divider.sv
// rtl/prog_freq_divider.sv - programmable divider with toggle, pulse and PWM outputs
module prog_freq_divider
    import prog_freq_divider_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [1:0]       mode_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             pending,
    output logic             tick,
    output logic             q
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] d_act;
    mode_t            mode_act;
    logic [WIDTH-1:0] sh_div;
    logic [WIDTH-1:0] sh_duty;
    mode_t            sh_mode;
    logic             wrap;
    logic             apply;
    logic             mode_change;

    assign wrap        = ena && (count == n_act - WIDTH'(1));
    assign apply       = wrap && pending;
    assign mode_change = apply && (sh_mode != mode_act);

    div_shadow_regs #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .div_in   (div_in),
        .duty_in  (duty_in),
        .mode_in  (mode_in),
        .div_load (div_load),
        .apply    (apply),
        .sh_div   (sh_div),
        .sh_duty  (sh_duty),
        .sh_mode  (sh_mode),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .pending  (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            tick     <= 1'b0;
            q        <= 1'b0;
            n_act    <= WIDTH'(DEFAULT_DIV);
            d_act    <= WIDTH'(DEFAULT_DIV / 2);
            mode_act <= MODE_TOGGLE;
        end else begin
            tick <= wrap;
            if (ena) begin
                count <= wrap ? '0 : count + WIDTH'(1);
            end
            if (apply) begin
                n_act    <= sh_div;
                d_act    <= sh_duty;
                mode_act <= sh_mode;
            end
            // The output restarts low whenever a new mode takes over.
            if (mode_change) begin
                q <= 1'b0;
            end else begin
                case (mode_act)
                    MODE_TOGGLE: if (wrap) q <= ~q;
                    MODE_PULSE:  q <= wrap;
                    MODE_PWM:    if (ena) q <= (count < d_act);
                    default:     q <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_freq_divider.sv
// tb/tb_prog_freq_divider.sv - directed self-checking bench for prog_freq_divider
module tb_prog_freq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic [15:0] div_in = '0;
    logic [15:0] duty_in = '0;
    logic [1:0]  mode_in = '0;
    logic        div_load = 1'b0;
    logic        div_ack, div_err, pending, tick, q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic ena;
        logic exp_tick;
        logic exp_q;
    } vec_t;

    vec_t tbl[21];

    prog_freq_divider #(.WIDTH(16), .DEFAULT_DIV(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .div_in   (div_in),
        .duty_in  (duty_in),
        .mode_in  (mode_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .pending  (pending),
        .tick     (tick),
        .q        (q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b1;
        div_load = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_load(input logic [15:0] n, input logic [15:0] d, input logic [1:0] m);
        div_load = 1'b1;
        div_in   = n;
        duty_in  = d;
        mode_in  = m;
    endtask

    initial begin
        for (int i = 0; i < 21; i++) begin
            tbl[i].ena      = 1'b1;
            tbl[i].exp_tick = (i + 1 == 10) || (i + 1 == 20);
            tbl[i].exp_q    = (i + 1 >= 10) && (i + 1 < 20);
        end

        // Default divide-by-10 toggle after reset
        do_reset();
        chk("reset_q", q, 1'b0);
        chk("reset_tick", tick, 1'b0);
        chk("reset_ack", div_ack, 1'b0);
        chk("reset_err", div_err, 1'b0);
        chk("reset_pending", pending, 1'b0);
        for (int i = 0; i < 21; i++) begin
            ena = tbl[i].ena;
            step();
            chk("default_tick", tick, tbl[i].exp_tick);
            chk("default_q", q, tbl[i].exp_q);
        end

        // PWM N=4 D=1 loaded mid-period
        do_reset();
        repeat (3) step();
        set_load(16'd4, 16'd1, 2'd2);
        step();
        div_load = 1'b0;
        chk("pwm_ack", div_ack, 1'b1);
        chk("pwm_err", div_err, 1'b0);
        chk("pwm_pending", pending, 1'b1);
        step();
        chk("pwm_ack_pulse", div_ack, 1'b0);
        repeat (4) step();
        chk("pwm_pending_hold", pending, 1'b1);
        step();
        chk("pwm_wrap_tick", tick, 1'b1);
        chk("pwm_wrap_pending", pending, 1'b0);
        chk("pwm_restart_q", q, 1'b0);
        for (int k = 11; k <= 22; k++) begin
            step();
            chk("pwm_q", q, ((k - 11) % 4) == 0);
            chk("pwm_tick", tick, ((k - 10) % 4) == 0);
        end

        // Rejected loads: zero divisor, reserved mode
        do_reset();
        repeat (2) step();
        set_load(16'd0, 16'd3, 2'd0);
        step();
        chk("err_zero", div_err, 1'b1);
        chk("err_zero_ack", div_ack, 1'b0);
        chk("err_zero_pending", pending, 1'b0);
        set_load(16'd5, 16'd3, 2'd3);
        step();
        div_load = 1'b0;
        chk("err_mode", div_err, 1'b1);
        chk("err_mode_ack", div_ack, 1'b0);
        chk("err_mode_pending", pending, 1'b0);
        step();
        chk("err_pulse", div_err, 1'b0);
        repeat (4) step();
        chk("err_no_early_tick", tick, 1'b0);
        step();
        chk("err_tick", tick, 1'b1);
        chk("err_q", q, 1'b1);

        // Two loads in one period: last one wins
        do_reset();
        repeat (2) step();
        set_load(16'd5, 16'd0, 2'd0);
        step();
        div_load = 1'b0;
        chk("two_ack1", div_ack, 1'b1);
        step();
        chk("two_ack_gap", div_ack, 1'b0);
        set_load(16'd7, 16'd0, 2'd0);
        step();
        div_load = 1'b0;
        chk("two_ack2", div_ack, 1'b1);
        chk("two_pending", pending, 1'b1);
        repeat (5) step();
        chk("two_wrap_tick", tick, 1'b1);
        chk("two_wrap_pending", pending, 1'b0);
        chk("two_wrap_q", q, 1'b1);
        for (int k = 11; k <= 24; k++) begin
            step();
            chk("two_tick", tick, (k == 17) || (k == 24));
            if (k == 17) chk("two_q17", q, 1'b0);
            if (k == 24) chk("two_q24", q, 1'b1);
        end

        // Freeze at count=6 with PULSE N=3 pending
        do_reset();
        repeat (2) step();
        set_load(16'd3, 16'd0, 2'd1);
        step();
        div_load = 1'b0;
        chk("frz_ack", div_ack, 1'b1);
        repeat (3) step();
        ena = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("frz_pending", pending, 1'b1);
            chk("frz_tick", tick, 1'b0);
            chk("frz_q", q, 1'b0);
        end
        ena = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            chk("frz_resume_tick", tick, (j == 4) || (j == 7) || (j == 10));
            if (j == 3) chk("frz_pending_pre", pending, 1'b1);
            if (j == 4) chk("frz_pending_post", pending, 1'b0);
            if (j > 4) chk("frz_pulse_q", q, tick);
        end

        // Reset with a pending request discards it
        set_load(16'd6, 16'd0, 2'd0);
        step();
        chk("rst_pre_ack", div_ack, 1'b1);
        chk("rst_pre_pending", pending, 1'b1);
        set_load(16'd2, 16'd0, 2'd0);
        rst = 1'b1;
        step();
        chk("rst_q", q, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_ack", div_ack, 1'b0);
        chk("rst_err", div_err, 1'b0);
        chk("rst_pending", pending, 1'b0);
        rst = 1'b0;
        div_load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("rst_after_tick", tick, k == 10);
        end
        chk("rst_after_q", q, 1'b1);

        // N=1, then PWM with duty above N
        do_reset();
        set_load(16'd1, 16'd0, 2'd0);
        step();
        div_load = 1'b0;
        chk("n1_ack", div_ack, 1'b1);
        repeat (9) step();
        chk("n1_first_tick", tick, 1'b1);
        chk("n1_first_q", q, 1'b1);
        for (int k = 11; k <= 13; k++) begin
            step();
            chk("n1_tick", tick, 1'b1);
            chk("n1_q", q, (k % 2) == 0);
        end
        set_load(16'd4, 16'd9, 2'd2);
        step();
        div_load = 1'b0;
        chk("dmax_pending", pending, 1'b1);
        chk("dmax_q_toggle", q, 1'b1);
        step();
        chk("dmax_restart_q", q, 1'b0);
        chk("dmax_applied", pending, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("dmax_q", q, 1'b1);
        end
        ena = 1'b0;
        step();
        chk("dmax_idle_tick", tick, 1'b0);
        chk("dmax_idle_q", q, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
